// File: rtl/uart_pkg.sv
// uart_pkg: shared UART payload width, FIFO depth default and FIFO status record.
package uart_pkg;
  localparam int UART_DATA_W = 8;
  localparam int UART_FIFO_DEPTH_DEFAULT = 16;
  typedef struct packed {
    logic full;
    logic empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;
  localparam fifo_status_t FIFO_STATUS_RST = '{full: 1'b0, empty: 1'b1, overflow: 1'b0, underflow: 1'b0};
endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: DEPTH x DATA_W register array, sync write, async read, storage never reset.
module uart_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk)
    if (we) mem_q[waddr] <= wdata;
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FWFT byte FIFO between the host side and the UART core.
// Define UART_FIFO_WATERMARK_EN to add almost_full/almost_empty outputs.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int DEPTH = UART_FIFO_DEPTH_DEFAULT,
  parameter int ADDR_W = $clog2(DEPTH)
`ifdef UART_FIFO_WATERMARK_EN
  ,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
`endif
) (
  input  logic              glb_clk,
  input  logic              glb_rst,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
`ifdef UART_FIFO_WATERMARK_EN
  ,
  output logic              almost_full,
  output logic              almost_empty
`endif
);
  localparam int PW = ADDR_W + 1;
  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  fifo_status_t status_q, status_d;
  logic push_ok, pop_ok;
  always_comb begin
    push_ok = wr_en & (~status_q.full | rd_en);
    pop_ok = rd_en & ~status_q.empty;
    wr_ptr_d = flush ? '0 : wr_ptr_q + PW'(push_ok);
    rd_ptr_d = flush ? '0 : rd_ptr_q + PW'(pop_ok);
    count_d = flush ? '0 : count_q + PW'(push_ok) - PW'(pop_ok);
    status_d.full = count_d == PW'(DEPTH);
    status_d.empty = count_d == '0;
    // A new violation outranks clr_err; flush outranks both.
    status_d.overflow = ~flush & ((wr_en & ~push_ok) | (status_q.overflow & ~clr_err));
    status_d.underflow = ~flush & ((rd_en & status_q.empty) | (status_q.underflow & ~clr_err));
  end
  always_ff @(posedge glb_clk or posedge glb_rst)
    if (glb_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      status_q <= FIFO_STATUS_RST;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      status_q <= status_d;
    end
  uart_fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
    .clk  (glb_clk),
    .we   (push_ok & ~flush),
    .waddr(wr_ptr_q[ADDR_W-1:0]),
    .wdata(wr_data),
    .raddr(rd_ptr_q[ADDR_W-1:0]),
    .rdata(rd_data)
  );
  assign count = count_q;
  assign full = status_q.full;
  assign empty = status_q.empty;
  assign overflow = status_q.overflow;
  assign underflow = status_q.underflow;
`ifdef UART_FIFO_WATERMARK_EN
  logic almost_full_q, almost_full_d, almost_empty_q, almost_empty_d;
  always_comb begin
    almost_full_d = count_d >= PW'(AF_LEVEL);
    almost_empty_d = count_d <= PW'(AE_LEVEL);
  end
  always_ff @(posedge glb_clk or posedge glb_rst)
    if (glb_rst) begin
      almost_full_q <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      almost_full_q <= almost_full_d;
      almost_empty_q <= almost_empty_d;
    end
  assign almost_full = almost_full_q;
  assign almost_empty = almost_empty_q;
`endif
endmodule

// File: tb/tb_uart_sync_fifo.sv
// tb_uart_sync_fifo: scoreboard bench; stimulus queues expected pops, a monitor checks them.
module tb_uart_sync_fifo;
  logic clk = 0, rst = 1, flush = 0, wr_en = 0, rd_en = 0, clr_err = 0;
  logic [7:0] wr_data = 0, rd_data;
  logic full, empty, overflow, underflow;
  logic [4:0] count;
`ifdef UART_FIFO_WATERMARK_EN
  logic almost_full, almost_empty;
`endif
  int total = 0, bad = 0, mdl = 0;
  logic [7:0] exp_q[$];
  always #5 clk = ~clk;
  uart_sync_fifo dut (
    .glb_clk(clk), .glb_rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data), .full(full), .empty(empty), .count(count),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
`ifdef UART_FIFO_WATERMARK_EN
    , .almost_full(almost_full), .almost_empty(almost_empty)
`endif
  );
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, req);
    end
  endtask
  task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c = 1'b0);
    bit p;
    wr_en = w; wr_data = d; rd_en = r; clr_err = c;
    p = r && mdl > 0;
    if (w && (mdl < 16 || r)) begin
      exp_q.push_back(d);
      mdl++;
    end
    if (p) mdl--;
    @(posedge clk); #1;
    wr_en = 0; rd_en = 0; clr_err = 0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    fork
      forever begin
        @(negedge clk);
        chk("empty_vs_count", 32'(empty), 32'(count == 0));
        chk("full_vs_count", 32'(full), 32'(count == 16));
        chk("count_max", 32'(count <= 16), 1);
        if (rd_en && !empty && !flush && !rst) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL pop_unexpected: got %0h want none", rd_data);
          end else chk("pop_data", 32'(rd_data), 32'(exp_q.pop_front()));
        end
      end
    join_none
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_unf", 32'(underflow), 0);
    // single word
    cyc(1, 8'hA5, 0);
    chk("one_empty", 32'(empty), 0);
    chk("one_count", 32'(count), 1);
    chk("one_data", 32'(rd_data), 32'hA5);
    cyc(0, 0, 1);
    chk("one_pop_empty", 32'(empty), 1);
    chk("one_pop_count", 32'(count), 0);
    // fill, overflow, push+pop while full, drain
    for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0);
    chk("fill_full", 32'(full), 1);
    chk("fill_count", 32'(count), 16);
    cyc(1, 8'hFF, 0);
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_count", 32'(count), 16);
    cyc(1, 8'h55, 1);
    chk("fullrw_count", 32'(count), 16);
    chk("fullrw_full", 32'(full), 1);
    chk("fullrw_ovf_hold", 32'(overflow), 1);
    chk("fullrw_head", 32'(rd_data), 32'h01);
    for (int i = 0; i < 16; i++) cyc(0, 0, 1);
    chk("drain_empty", 32'(empty), 1);
    chk("drain_count", 32'(count), 0);
    chk("drain_sb", 32'(exp_q.size()), 0);
    cyc(0, 0, 0, 1);
    chk("ovf_clr", 32'(overflow), 0);
    // push+pop while empty
    cyc(1, 8'h3C, 1);
    chk("emptyrw_unf", 32'(underflow), 1);
    chk("emptyrw_count", 32'(count), 1);
    chk("emptyrw_data", 32'(rd_data), 32'h3C);
    cyc(0, 0, 0, 1);
    chk("unf_clr", 32'(underflow), 0);
    cyc(0, 0, 1);
    cyc(0, 0, 1, 1);
    chk("unf_set_wins", 32'(underflow), 1);
    cyc(0, 0, 0, 1);
    chk("unf_clr2", 32'(underflow), 0);
    // interleaved traffic across pointer wrap, then flush with push/pop asserted
    for (int i = 0; i < 40; i++) cyc(i % 5 != 4, 8'(8'h80 + i), i >= 3 && i % 4 != 0);
    chk("mix_count", 32'(count), 32'(mdl));
    flush = 1; wr_en = 1; wr_data = 8'hEE; rd_en = 1;
    @(posedge clk); #1;
    flush = 0; wr_en = 0; rd_en = 0;
    mdl = 0; exp_q.delete();
    chk("flush_count", 32'(count), 0);
    chk("flush_empty", 32'(empty), 1);
    chk("flush_full", 32'(full), 0);
    chk("flush_unf", 32'(underflow), 0);
    cyc(1, 8'h11, 0);
    chk("post_flush_data", 32'(rd_data), 32'h11);
    cyc(0, 0, 1);
    chk("post_flush_sb", 32'(exp_q.size()), 0);
    // asynchronous reset between edges
    cyc(0, 0, 1);
    chk("pre_rst_unf", 32'(underflow), 1);
    for (int i = 0; i < 7; i++) cyc(1, 8'(8'h20 + i), 0);
    chk("pre_rst_count", 32'(count), 7);
    wr_en = 1; wr_data = 8'h99;
    #2 rst = 1;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_empty", 32'(empty), 1);
    chk("arst_unf", 32'(underflow), 0);
    chk("arst_ovf", 32'(overflow), 0);
    exp_q.delete(); mdl = 0;
    @(posedge clk); #1;
    wr_en = 0; rst = 0;
    chk("arst_hold_count", 32'(count), 0);
    cyc(1, 8'h42, 0);
    chk("post_rst_data", 32'(rd_data), 32'h42);
    cyc(0, 0, 1);
    chk("final_sb", 32'(exp_q.size()), 0);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_sync_fifo.md
Name: uart_sync_fifo

Overview:
- Single-clock, first-word-fall-through (FWFT) byte FIFO that buffers between the host/register side and the UART core.
- Two instances per channel:
  - TX: host writes; the core pops via its FIFO read-enable and reads its TX payload.
  - RX: the core pushes via its FIFO write-enable; host pops.
- Supplies the full/empty indications the core gates on, plus an occupancy count and sticky error flags for the config/status block.

Parameters:
- DATA_W, 8, payload width in bits.
- DEPTH, 16, number of entries; must be a power of 2, minimum 2.
- ADDR_W, $clog2(DEPTH), pointer index width; derived, do not override.

Ports:
- glb_clk  in  1  system clock; all logic on rising edge.
- glb_rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous clear of pointers, count and error flags.
- wr_en  in  1  push request.
- wr_data  in  DATA_W  push data.
- rd_en  in  1  pop request.
- rd_data  out  DATA_W  head entry (FWFT); valid only while empty=0.
- full  out  1  DEPTH entries held.
- empty  out  1  0 entries held.
- count  out  ADDR_W+1  occupancy, 0..DEPTH.
- overflow  out  1  sticky: a push was attempted while full and not accepted.
- underflow  out  1  sticky: a pop was attempted while empty.
- clr_err  in  1  synchronous clear of overflow/underflow.

Behaviour:
- Reset (glb_rst=1, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, overflow=0, underflow=0.
  - rd_data is don't-care; memory contents are not reset.
- Pointers:
  - ADDR_W+1 bits wide; the MSB is a wrap bit.
  - Storage index is ptr[ADDR_W-1:0]; natural wrap from DEPTH-1 to 0.
- Accept rules, all evaluated on the same edge:
  - push_ok = wr_en & (~full | rd_en).
  - pop_ok = rd_en & ~empty.
  - When full, a simultaneous push+pop is accepted: count stays DEPTH, both pointers advance.
  - When empty, a simultaneous push+pop: push accepted, pop rejected, underflow set, count becomes 1.
- count update: count + push_ok - pop_ok, registered.
- full and empty are registered, computed from next-state count; both are always consistent with count.
- Latency:
  - A pushed word is visible on rd_data and empty falls on the cycle after the push edge.
  - Pop takes effect at the edge; the next head appears combinationally from memory at the new rd_ptr in the following cycle.
- rd_data = mem[rd_ptr index], read asynchronously (FWFT).
- flush:
  - Has priority over wr_en/rd_en in the same cycle.
  - Resets pointers and count to 0, empty=1, full=0.
  - Clears overflow and underflow.
  - Memory is untouched.
- Error flags:
  - Set on the violating edge and hold until clr_err, flush or reset.
  - If clr_err and a new violation occur in the same cycle, set wins.
- A rejected push or pop never modifies pointers or memory.

Optional Feature:
- Macro: UART_FIFO_WATERMARK_EN.
- Defined:
  - Adds parameter AF_LEVEL (default DEPTH-2) and AE_LEVEL (default 2).
  - Adds registered outputs almost_full (count >= AF_LEVEL) and almost_empty (count <= AE_LEVEL).
  - Both are derived from next-state count.
  - Reset values: almost_full=0, almost_empty=1.
- Undefined: these parameters and ports do not exist; all other behaviour is identical.

Decomposition:
- Shared package uart_pkg holds:
  - UART_DATA_W = 8.
  - UART_FIFO_DEPTH_DEFAULT = 16.
  - The FIFO status struct type {full, empty, overflow, underflow}, for the status register block.
- One sub-module: uart_fifo_mem.
  - DEPTH x DATA_W register array.
  - Synchronous write port (we, waddr, wdata).
  - Asynchronous read port (raddr, rdata).
  - No reset on storage.

Test Plan:
- Reset, then push 0xA5 (one cycle) -> next cycle empty=0, count=1, rd_data=0xA5; pop -> next cycle empty=1, count=0.
- Push 0x00..0x0F (16 words) -> full=1, count=16; push 0xFF -> overflow=1, word dropped; pop 16 -> data 0x00..0x0F in order, empty=1.
- Full FIFO, push 0x55 and pop in the same cycle -> count stays 16, popped 0x00, 0x55 later read as 16th word.
- Empty FIFO, push 0x3C and pop in the same cycle -> underflow=1, count=1, rd_data=0x3C; clr_err -> underflow=0.
- 40 interleaved push/pop cycles crossing pointer wrap twice -> scoreboard order match, count never exceeds 16; flush mid-stream -> count=0, empty=1, subsequent push 0x11 reads back 0x11.
- Assert glb_rst asynchronously mid-burst (between edges) with count=7 -> count=0, empty=1, flags cleared immediately without waiting for a clock edge.
